// File: rtl/ifetch_prefetch_buffer.sv
// Instruction prefetch queue: issues sequential word fetches to a synchronous
// instruction memory and hands {pc, instruction} pairs to IF over valid/ready.
module ifetch_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [31:0]              imem_addr,
    output logic                     imem_fetch_en,
    input  logic [31:0]              imem_read_data,
    output logic                     inst_valid,
    output logic [31:0]              inst_out,
    output logic [31:0]              inst_pc_out,
    input  logic                     inst_ready,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OW = CW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t          fifo_q [DEPTH];
    logic [31:0]     fetch_pc;
    logic [31:0]     pc_pending;
    logic            resp_pending;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    logic            pop_c;
    logic            push_c;
    logic            issue_c;
    logic            head_valid_c;
    logic [OW-1:0]   occupancy_c;
    logic [31:0]     redirect_target_c;

    // Handshake and issue decisions; redirect suppresses pop, push and issue.
    always_comb begin
        head_valid_c      = (count != '0) & ~redirect_valid;
        pop_c             = head_valid_c & inst_ready;
        push_c            = resp_pending & ~redirect_valid;
        occupancy_c       = OW'(count) + OW'(resp_pending) - OW'(pop_c);
        issue_c           = ~redirect_valid & (occupancy_c < OW'(DEPTH));
        redirect_target_c = redirect_pc & 32'hFFFF_FFFC;
    end

    assign imem_addr     = fetch_pc;
    assign imem_fetch_en = issue_c;
    assign inst_valid    = head_valid_c;
    assign inst_out      = fifo_q[rd_ptr].inst;
    assign inst_pc_out   = fifo_q[rd_ptr].pc;
    assign level         = count;

    // Fetch pointer, in-flight tracking and FIFO bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc     <= RESET_PC;
            pc_pending   <= '0;
            resp_pending <= 1'b0;
            count        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc     <= redirect_target_c;
            resp_pending <= 1'b0;
            count        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
        end else begin
            resp_pending <= issue_c;
            if (issue_c) begin
                pc_pending <= fetch_pc;
                fetch_pc   <= fetch_pc + 32'd4;
            end
            if (push_c) begin
                fifo_q[wr_ptr] <= '{pc: pc_pending, inst: imem_read_data};
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_c && !pop_c) begin
                count <= count + CW'(1);
            end else if (pop_c && !push_c) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// Scoreboard bench for ifetch_prefetch_buffer: expected PCs are queued as
// stimulus is driven and compared against every accepted head entry.
module tb_ifetch_prefetch_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT, RESET_PC = 0
    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_fetch_en;
    logic [31:0] imem_read_data;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc_out;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  level;

    // Second DUT exercising fetch_pc wrap
    logic        rst_n_b;
    logic [31:0] imem_addr_b;
    logic        imem_fetch_en_b;
    logic [31:0] imem_read_data_b;
    logic        inst_valid_b;
    logic [31:0] inst_out_b;
    logic [31:0] inst_pc_out_b;
    logic [2:0]  level_b;

    ifetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_fetch_en  (imem_fetch_en),
        .imem_read_data (imem_read_data),
        .inst_valid     (inst_valid),
        .inst_out       (inst_out),
        .inst_pc_out    (inst_pc_out),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .level          (level)
    );

    ifetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk            (clk),
        .rst_n          (rst_n_b),
        .imem_addr      (imem_addr_b),
        .imem_fetch_en  (imem_fetch_en_b),
        .imem_read_data (imem_read_data_b),
        .inst_valid     (inst_valid_b),
        .inst_out       (inst_out_b),
        .inst_pc_out    (inst_pc_out_b),
        .inst_ready     (1'b1),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .level          (level_b)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_pc;
    logic [31:0] b_exp [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    int          b_idx = 0;
    int          cycles;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[7:0], pc[31:8]} ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Synchronous instruction memory models
    always @(posedge clk) begin
        imem_read_data   <= inst_of(imem_addr);
        imem_read_data_b <= inst_of(imem_addr_b);
    end

    // Scoreboard: compare each accepted head entry with the queued expectation
    always @(negedge clk) begin
        if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 32'(inst_valid), 32'd0);
            end else begin
                mon_pc = exp_q.pop_front();
                check("pop_pc", inst_pc_out, mon_pc);
                check("pop_inst", inst_out, inst_of(mon_pc));
            end
        end
    end

    always @(negedge clk) begin
        if (inst_valid_b === 1'b1 && b_idx < 4) begin
            check("wrap_pc", inst_pc_out_b, b_exp[b_idx]);
            check("wrap_inst", inst_out_b, inst_of(b_exp[b_idx]));
            b_idx++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic wait_drain(input int budget, output int used);
        used = 0;
        while (exp_q.size() != 0 && used < budget) begin
            step();
            used++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        inst_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        rst_n_b        = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        step();
        step();
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_inst", inst_out, 32'd0);
        check("rst_pc", inst_pc_out, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_addr_b", imem_addr_b, 32'hFFFF_FFF8);

        // Reset release with IF always ready: latency and 1/cycle throughput
        push_seq(32'h0, 8);
        inst_ready = 1'b1;
        rst_n      = 1'b1;
        rst_n_b    = 1'b1;
        step();
        check("lat_edge1_valid", 32'(inst_valid), 32'd0);
        check("lat_edge1_addr", imem_addr, 32'h4);
        step();
        check("lat_edge2_valid", 32'(inst_valid), 32'd1);
        check("lat_edge2_pc", inst_pc_out, 32'h0);
        wait_drain(30, cycles);
        check("throughput_cycles", 32'(cycles), 32'd8);

        // Asynchronous reset mid-stream with two entries buffered
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        step();
        check("pre_reset_level", 32'(level), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_level", 32'(level), 32'd0);
        check("async_rst_valid", 32'(inst_valid), 32'd0);
        check("async_rst_addr", imem_addr, 32'd0);
        step();
        rst_n = 1'b1;

        // Backpressure: FIFO fills to DEPTH and fetching stops
        repeat (10) step();
        check("bp_level", 32'(level), 32'd4);
        check("bp_fetch_en", 32'(imem_fetch_en), 32'd0);
        check("bp_addr", imem_addr, 32'h10);
        push_seq(32'h0, 6);
        inst_ready = 1'b1;
        wait_drain(30, cycles);

        // Redirect while level=3 with a response in flight
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        repeat (4) step();
        check("pre_redir_level", 32'(level), 32'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        #1;
        check("redir_valid_forced", 32'(inst_valid), 32'd0);
        check("redir_fetch_en", 32'(imem_fetch_en), 32'd0);
        step();
        redirect_valid = 1'b0;
        check("post_redir_level", 32'(level), 32'd0);
        check("post_redir_valid", 32'(inst_valid), 32'd0);
        check("post_redir_addr", imem_addr, 32'h40);
        push_seq(32'h40, 4);
        inst_ready = 1'b1;
        step();
        check("redir_edge1_valid", 32'(inst_valid), 32'd0);
        step();
        check("redir_edge2_valid", 32'(inst_valid), 32'd1);
        wait_drain(30, cycles);

        // Redirect coinciding with inst_ready and a pending response; unaligned target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        redirect_valid = 1'b0;
        repeat (3) step();
        check("pre_redir2_level", 32'(level), 32'd2);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        #1;
        check("redir2_valid_forced", 32'(inst_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        check("post_redir2_level", 32'(level), 32'd0);
        check("post_redir2_addr", imem_addr, 32'h100);
        push_seq(32'h100, 3);
        wait_drain(30, cycles);

        // Back-to-back redirects: the last one wins
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        step();
        redirect_pc    = 32'h600;
        step();
        redirect_valid = 1'b0;
        check("b2b_addr", imem_addr, 32'h600);
        push_seq(32'h600, 2);
        inst_ready = 1'b1;
        wait_drain(30, cycles);

        repeat (2) step();
        check("wrap_pops_seen", 32'(b_idx), 32'd4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
